// File: rtl/moore_run_detector.sv
// Moore run-length detector: z=1 while the qualified input has been active for
// >= RUN_LEN consecutive enabled samples. Optional macro DETECT_CNT_EN adds det_cnt.
module moore_run_detector #(
   parameter int RUN_LEN = 2,
   parameter int CNT_W   = 4
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             en,
   input  logic             clr,
   input  logic             pol,
   input  logic             w,
   output logic             z,
   output logic             rise,
`ifdef DETECT_CNT_EN
   output logic [15:0]      det_cnt,
`endif
   output logic [CNT_W-1:0] run_cnt
);

   if (RUN_LEN < 1 || RUN_LEN > (2**CNT_W) - 1) begin : g_bad_run_len
      $error("moore_run_detector: RUN_LEN out of range 1..2**CNT_W-1");
   end

   localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      COUNT  = 2'b01,
      DETECT = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rise_q, rise_d;
   logic             act;
   logic [CNT_W-1:0] cnt_inc;

   assign act     = w ^ pol;
   assign cnt_inc = cnt_q + ONE;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = rise_q;
      if (clr) begin
         state_d = IDLE;
         cnt_d   = '0;
         rise_d  = 1'b0;
      end else if (en) begin
         rise_d  = 1'b0;
         state_d = IDLE;
         cnt_d   = '0;
         case (state_q)
            IDLE: begin
               if (act) begin
                  cnt_d   = ONE;
                  state_d = (RUN_MAX == ONE) ? DETECT : COUNT;
                  rise_d  = (RUN_MAX == ONE);
               end
            end
            COUNT: begin
               if (act) begin
                  cnt_d   = cnt_inc;
                  state_d = (cnt_inc == RUN_MAX) ? DETECT : COUNT;
                  rise_d  = (cnt_inc == RUN_MAX);
               end
            end
            DETECT: begin
               // Counter is pinned at RUN_LEN so it never wraps on long runs.
               if (act) begin
                  cnt_d   = RUN_MAX;
                  state_d = DETECT;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
      end
   end

`ifdef DETECT_CNT_EN
   logic [15:0] det_cnt_q, det_cnt_d;

   // Counts entries into DETECT, i.e. the same events that raise rise.
   always_comb begin
      det_cnt_d = det_cnt_q;
      if (clr)
         det_cnt_d = '0;
      else if (en && rise_d && det_cnt_q != 16'hFFFF)
         det_cnt_d = det_cnt_q + 16'd1;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) det_cnt_q <= '0;
      else         det_cnt_q <= det_cnt_d;
   end

   assign det_cnt = det_cnt_q;
`endif

   assign z       = (state_q == DETECT);
   assign rise    = rise_q;
   assign run_cnt = cnt_q;

endmodule

// File: tb/tb_moore_run_detector.sv
// Bench for moore_run_detector: four instances (RUN_LEN=1..4) sharing stimulus,
// checked by vector tables, directed corner sequences and a run-length model.
module tb_moore_run_detector;

   logic Clock = 1'b0;
   logic Resetn, en, clr, pol, w;
   logic [3:0]       z_v, rise_v;
   logic [3:0][3:0]  cnt_v;
`ifdef DETECT_CNT_EN
   logic [3:0][15:0] det_v;
`endif

   always #5 Clock = ~Clock;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      moore_run_detector #(.RUN_LEN(g + 1), .CNT_W(4)) u_dut (
         .Clock   (Clock),
         .Resetn  (Resetn),
         .en      (en),
         .clr     (clr),
         .pol     (pol),
         .w       (w),
         .z       (z_v[g]),
         .rise    (rise_v[g]),
`ifdef DETECT_CNT_EN
         .det_cnt (det_v[g]),
`endif
         .run_cnt (cnt_v[g])
      );
   end

   int checks = 0;
   int failures = 0;

   // Reference model: length of the current run of active samples.
   int run_m[4];
   bit rise_m[4];
   int det_m[4];

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         run_m[i] = 0; rise_m[i] = 0; det_m[i] = 0;
      end
   endfunction

   function automatic void model_step();
      for (int i = 0; i < 4; i++) begin
         int  len = i + 1;
         bit  was_det;
         if (clr) begin
            run_m[i] = 0; rise_m[i] = 0; det_m[i] = 0;
         end else if (en) begin
            was_det  = (run_m[i] >= len);
            run_m[i] = ((w ^ pol) == 1'b1) ? run_m[i] + 1 : 0;
            if (run_m[i] > 1000) run_m[i] = 1000;
            rise_m[i] = (run_m[i] >= len) && !was_det;
            if (rise_m[i] && det_m[i] < 65535) det_m[i]++;
         end
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      for (int i = 0; i < 4; i++) begin
         int len = i + 1;
         chk($sformatf("%s L%0d z", tag, len), int'(z_v[i]), (run_m[i] >= len) ? 1 : 0);
         chk($sformatf("%s L%0d rise", tag, len), int'(rise_v[i]), int'(rise_m[i]));
         chk($sformatf("%s L%0d run_cnt", tag, len), int'(cnt_v[i]),
             (run_m[i] < len) ? run_m[i] : len);
`ifdef DETECT_CNT_EN
         chk($sformatf("%s L%0d det_cnt", tag, len), int'(det_v[i]), det_m[i]);
`endif
      end
   endtask

   // Inputs are stable across the edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge Clock);
      model_step();
      #1;
   endtask

   task automatic set_in(input logic c, input logic e, input logic p, input logic wi);
      clr = c; en = e; pol = p; w = wi;
   endtask

   task automatic do_clr();
      set_in(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      clr = 1'b0;
   endtask

   typedef struct {
      logic clr, en, pol, w;
      int   z, rise, cnt;
   } vec_t;

   vec_t tbl[11];

   initial begin
      // RUN_LEN=2 instance: basic run, polarity, hold, clear.
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 2};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 2};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 2};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 2};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0};

      Resetn = 1'b0;
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      model_reset();
      #2;
      chk_model("reset");
      chk("reset z", int'(z_v), 0);
      #10 Resetn = 1'b1;

      for (int i = 0; i < 11; i++) begin
         set_in(tbl[i].clr, tbl[i].en, tbl[i].pol, tbl[i].w);
         tick();
         chk($sformatf("tbl%0d z", i), int'(z_v[1]), tbl[i].z);
         chk($sformatf("tbl%0d rise", i), int'(rise_v[1]), tbl[i].rise);
         chk($sformatf("tbl%0d run_cnt", i), int'(cnt_v[1]), tbl[i].cnt);
      end

      // Broken run must not detect early on RUN_LEN=4.
      begin
         int wseq[8];
         int cexp[8];
         wseq = '{1, 1, 1, 0, 1, 1, 1, 1};
         cexp = '{1, 2, 3, 0, 1, 2, 3, 4};
         do_clr();
         for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 1'b1, 1'b0, wseq[i][0]);
            tick();
            chk($sformatf("len4 e%0d run_cnt", i + 1), int'(cnt_v[3]), cexp[i]);
            chk($sformatf("len4 e%0d z", i + 1), int'(z_v[3]), (i == 7) ? 1 : 0);
         end
      end

      // Inverted polarity on RUN_LEN=3, then same stimulus non-inverted.
      for (int p = 1; p >= 0; p--) begin
         int wseq[4];
         wseq = '{0, 0, 0, 1};
         do_clr();
         for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, p[0], wseq[i][0]);
            tick();
            chk($sformatf("pol%0d e%0d z", p, i + 1), int'(z_v[2]),
                (p == 1 && i == 2) ? 1 : 0);
         end
      end

      // Freeze in DETECT with en=0, then clr overrides en=0.
      do_clr();
      set_in(1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, 1'b0, 1'b0, i[0]);
         tick();
         chk($sformatf("hold%0d z", i), int'(z_v[1]), 1);
         chk($sformatf("hold%0d rise", i), int'(rise_v[1]), 1);
         chk($sformatf("hold%0d run_cnt", i), int'(cnt_v[1]), 2);
      end
      set_in(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      chk("clr_en0 z", int'(z_v[1]), 0);
      chk("clr_en0 run_cnt", int'(cnt_v[1]), 0);
      chk("clr_en0 rise", int'(rise_v[1]), 0);

      // Asynchronous reset mid-run on RUN_LEN=3.
      do_clr();
      set_in(1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      tick();
      chk("pre_rst run_cnt", int'(cnt_v[2]), 2);
      #2 Resetn = 1'b0;
      #1;
      model_reset();
      chk("async_rst z", int'(z_v), 0);
      chk("async_rst run_cnt", int'(cnt_v[2]), 0);
      chk("async_rst rise", int'(rise_v), 0);
      #1 Resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post_rst e%0d z", i + 1), int'(z_v[2]), (i == 2) ? 1 : 0);
      end

`ifdef DETECT_CNT_EN
      do_clr();
      for (int r = 0; r < 3; r++) begin
         set_in(1'b0, 1'b1, 1'b0, 1'b1); tick(); tick();
         set_in(1'b0, 1'b1, 1'b0, 1'b0); tick();
      end
      chk("det_cnt 3 runs", int'(det_v[1]), 3);
      do_clr();
      chk("det_cnt clr", int'(det_v[1]), 0);
`endif

      chk_model("pre_rand");

      // Randomised phase: long-ish runs, occasional hold, clear and reset.
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 600; c++) begin
         en  = ($urandom_range(0, 7) != 0);
         clr = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 49) == 0) pol = ~pol;
         if ($urandom_range(0, 3) == 0) w = ~w;
         if ($urandom_range(0, 99) == 0) begin
            #2 Resetn = 1'b0;
            #1 model_reset();
            chk_model("rand_rst");
            #1 Resetn = 1'b1;
         end
         tick();
         chk_model($sformatf("rand%0d", c));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
